// File: rtl/firebird7_in_gate1_tessent_scanmux_nway_sel.sv
// N-way IJTAG scan-path mux whose select comes from its own shift/capture/update SCR segment.
// Optional build macro FIREBIRD7_SCANMUX_SECURE_LOCK_EN adds lock_in, which pins the select to RESET_SEL.
module firebird7_in_gate1_tessent_scanmux_nway_sel #(
    parameter int NUM_INPUTS = 4,
    parameter int SEL_WIDTH  = $clog2(NUM_INPUTS),
    parameter int RESET_SEL  = 0
) (
    input  logic                  ijtag_tck,
    input  logic                  ijtag_reset,
    input  logic                  ijtag_sel,
    input  logic                  ijtag_si,
    input  logic                  ijtag_ce,
    input  logic                  ijtag_se,
    input  logic                  ijtag_ue,
    output logic                  ijtag_so,
`ifdef FIREBIRD7_SCANMUX_SECURE_LOCK_EN
    input  logic                  lock_in,
`endif
    input  logic [NUM_INPUTS-1:0] mux_in,
    output logic                  mux_out,
    input  logic                  enable_in,
    output logic [NUM_INPUTS-1:0] enable_out,
    output logic [SEL_WIDTH-1:0]  sel_value,
    output logic                  update_reject
);

    localparam logic [SEL_WIDTH-1:0] RESET_VAL = SEL_WIDTH'(RESET_SEL);
    localparam logic [SEL_WIDTH:0]   SEL_LIMIT = (SEL_WIDTH + 1)'(NUM_INPUTS);

    logic [SEL_WIDTH-1:0] shreg_reg;
    logic [SEL_WIDTH-1:0] shreg_next;
    logic [SEL_WIDTH-1:0] upd_reg;
    logic [SEL_WIDTH-1:0] upd_next;
    logic                 reject_reg;
    logic                 reject_next;
    logic [SEL_WIDTH-1:0] shift_val;
    logic                 cand_ok;
    logic                 lock_force;

    // A one-bit register has no upper slice to shift down, so it just reloads from si.
    generate
        if (SEL_WIDTH == 1) begin : g_shift_single
            assign shift_val = ijtag_si;
        end else begin : g_shift_multi
            assign shift_val = {ijtag_si, shreg_reg[SEL_WIDTH-1:1]};
        end
    endgenerate

`ifdef FIREBIRD7_SCANMUX_SECURE_LOCK_EN
    assign cand_ok    = ({1'b0, shreg_reg} < SEL_LIMIT) &&
                        (!lock_in || (shreg_reg == RESET_VAL));
    assign lock_force = lock_in && (upd_reg != RESET_VAL);
`else
    assign cand_ok    = ({1'b0, shreg_reg} < SEL_LIMIT);
    assign lock_force = 1'b0;
`endif

    always_comb begin
        shreg_next  = shreg_reg;
        upd_next    = upd_reg;
        reject_next = 1'b0;
        if (ijtag_sel) begin
            if (ijtag_ce) begin
                shreg_next = upd_reg;
            end else if (ijtag_se) begin
                shreg_next = shift_val;
            end
            // The update candidate is the pre-edge shreg, so shift/capture above do not affect it.
            if (ijtag_ue) begin
                if (cand_ok) begin
                    upd_next = shreg_reg;
                end else begin
                    reject_next = 1'b1;
                end
            end
        end
        if (lock_force) begin
            upd_next = RESET_VAL;
        end
    end

    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            shreg_reg  <= RESET_VAL;
            upd_reg    <= RESET_VAL;
            reject_reg <= 1'b0;
        end else begin
            shreg_reg  <= shreg_next;
            upd_reg    <= upd_next;
            reject_reg <= reject_next;
        end
    end

    assign ijtag_so      = shreg_reg[0];
    assign sel_value     = upd_reg;
    assign update_reject = reject_reg;
    assign mux_out       = mux_in[upd_reg];

    // upd_reg only ever holds one legal value, so the decode is one-hot or all-zero by construction.
    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_enable
            assign enable_out[gi] = enable_in && (upd_reg == SEL_WIDTH'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_scanmux_nway_sel.sv
// Bench for the N-way scan mux: two instances (4-way reset 0, 3-way reset 1) checked against a value-level model.
module tb_firebird7_in_gate1_tessent_scanmux_nway_sel;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sel = 1'b0;
    logic       si  = 1'b0;
    logic       ce  = 1'b0;
    logic       se  = 1'b0;
    logic       ue  = 1'b0;
    logic       en  = 1'b0;
    logic       lock = 1'b0;
    logic [3:0] mux_in_a = '0;
    logic [2:0] mux_in_b = '0;

    logic       so_a, so_b, mo_a, mo_b, rej_a, rej_b;
    logic [3:0] en_a;
    logic [2:0] en_b;
    logic [1:0] sel_a, sel_b;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model state per instance: plain integers for the shift register and the active select.
    int m_sh[2];
    int m_upd[2];
    int m_rej[2];

    always #5 clk = ~clk;

    firebird7_in_gate1_tessent_scanmux_nway_sel #(
        .NUM_INPUTS(4), .RESET_SEL(0)
    ) dut_a (
        .ijtag_tck(clk), .ijtag_reset(rst), .ijtag_sel(sel), .ijtag_si(si),
        .ijtag_ce(ce), .ijtag_se(se), .ijtag_ue(ue), .ijtag_so(so_a),
`ifdef FIREBIRD7_SCANMUX_SECURE_LOCK_EN
        .lock_in(lock),
`endif
        .mux_in(mux_in_a), .mux_out(mo_a), .enable_in(en), .enable_out(en_a),
        .sel_value(sel_a), .update_reject(rej_a)
    );

    firebird7_in_gate1_tessent_scanmux_nway_sel #(
        .NUM_INPUTS(3), .RESET_SEL(1)
    ) dut_b (
        .ijtag_tck(clk), .ijtag_reset(rst), .ijtag_sel(sel), .ijtag_si(si),
        .ijtag_ce(ce), .ijtag_se(se), .ijtag_ue(ue), .ijtag_so(so_b),
`ifdef FIREBIRD7_SCANMUX_SECURE_LOCK_EN
        .lock_in(lock),
`endif
        .mux_in(mux_in_b), .mux_out(mo_b), .enable_in(en), .enable_out(en_b),
        .sel_value(sel_b), .update_reject(rej_b)
    );

    function automatic int num_of(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic int rst_of(input int k);
        return (k == 0) ? 0 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Rules applied at each tck edge: update uses the old shift value, capture beats shift.
    task automatic model_step(input int k);
        int cand;
        int nu;
        int rj;
        cand = m_sh[k];
        nu   = m_upd[k];
        rj   = 0;
        if (sel) begin
            if (ue) begin
                if (cand < num_of(k) && !(lock && cand != rst_of(k))) nu = cand;
                else rj = 1;
            end
            if (ce) m_sh[k] = m_upd[k];
            else if (se) m_sh[k] = (m_sh[k] >> 1) + (int'(si) * 2);
        end
        if (lock && m_upd[k] != rst_of(k)) nu = rst_of(k);
        m_upd[k] = nu;
        m_rej[k] = rj;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_sh[k]  = rst_of(k);
                m_upd[k] = rst_of(k);
                m_rej[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("sel_a", 32'(sel_a), 32'(m_upd[0]));
            check("sel_b", 32'(sel_b), 32'(m_upd[1]));
            check("so_a", 32'(so_a), 32'(m_sh[0] % 2));
            check("so_b", 32'(so_b), 32'(m_sh[1] % 2));
            check("rej_a", 32'(rej_a), 32'(m_rej[0]));
            check("rej_b", 32'(rej_b), 32'(m_rej[1]));
            check("mux_a", 32'(mo_a), 32'(mux_in_a[m_upd[0]]));
            check("mux_b", 32'(mo_b), 32'(mux_in_b[m_upd[1]]));
            check("en_a", 32'(en_a), en ? (32'd1 << m_upd[0]) : 32'd0);
            check("en_b", 32'(en_b), en ? (32'd1 << m_upd[1]) : 32'd0);
            check("onehot_a", 32'($countones(en_a) <= 1), 32'd1);
            check("onehot_b", 32'($countones(en_b) <= 1), 32'd1);
        end
    end

    // Inputs are applied 1 time unit after an edge and held across the next rising edge.
    task automatic step(input logic s, input logic i, input logic c, input logic sh,
                        input logic u, input logic e);
        sel = s; si = i; ce = c; se = sh; ue = u; en = e;
        mux_in_a = 4'($urandom);
        mux_in_b = 3'($urandom);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        en = 1'b1;
        mux_in_a = 4'b0001;
        #1;
        check("lit_reset_sel_a", 32'(sel_a), 32'd0);
        check("lit_reset_sel_b", 32'(sel_b), 32'd1);
        check("lit_reset_en_a", 32'(en_a), 32'b0001);
        check("lit_reset_so_a", 32'(so_a), 32'd0);
        check("lit_reset_mux_a1", 32'(mo_a), 32'd1);
        mux_in_a = 4'b1110;
        #1;
        check("lit_reset_mux_a0", 32'(mo_a), 32'd0);

        // Shift 2'b10 in LSB-first, then update.
        step(1, 0, 0, 1, 0, 1);
        step(1, 1, 0, 1, 0, 1);
        step(1, 0, 0, 0, 1, 1);
        check("lit_upd2_sel_a", 32'(sel_a), 32'd2);
        check("lit_upd2_en_a", 32'(en_a), 32'b0100);
        check("lit_upd2_sel_b", 32'(sel_b), 32'd2);
        mux_in_a = 4'b0100;
        #1;
        check("lit_upd2_mux_a", 32'(mo_a), 32'd1);
        step(1, 0, 1, 0, 0, 1);
        check("lit_capture_so0", 32'(so_a), 32'd0);
        step(1, 0, 0, 1, 0, 1);
        check("lit_capture_so1", 32'(so_a), 32'd1);

        // Shift 3 in: legal for the 4-way, out of range for the 3-way.
        step(1, 1, 0, 1, 0, 1);
        step(1, 1, 0, 1, 0, 1);
        step(1, 0, 0, 0, 1, 1);
        check("lit_rej_sel_a", 32'(sel_a), 32'd3);
        check("lit_rej_sel_b", 32'(sel_b), 32'd2);
        check("lit_rej_pulse_b", 32'(rej_b), 32'd1);
        check("lit_rej_en_b", 32'(en_b), 32'b100);
        step(1, 0, 0, 0, 0, 1);
        check("lit_rej_clear_b", 32'(rej_b), 32'd0);
        step(1, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 1, 1);
        check("lit_rej_b2b", 32'(rej_b), 32'd1);

        // Deselected segment ignores all strobes.
        for (int n = 0; n < 10; n++) begin
            step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1);
        end
        check("lit_desel_sel_a", 32'(sel_a), 32'd3);
        check("lit_desel_rej_b", 32'(rej_b), 32'd0);

        // Back to select 2, then reset in the middle of a shift.
        step(1, 0, 0, 1, 0, 1);
        step(1, 1, 0, 1, 0, 1);
        step(1, 0, 0, 0, 1, 1);
        check("lit_pre_rst_sel_a", 32'(sel_a), 32'd2);
        step(1, 1, 0, 1, 0, 1);
        #2 rst = 1'b1;
        #1;
        check("lit_midrst_sel_a", 32'(sel_a), 32'd0);
        check("lit_midrst_en_a", 32'(en_a), 32'b0001);
        check("lit_midrst_sel_b", 32'(sel_b), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

`ifdef FIREBIRD7_SCANMUX_SECURE_LOCK_EN
        lock = 1'b1;
        step(1, 1, 0, 1, 0, 1);
        step(1, 0, 0, 1, 0, 1);
        step(1, 0, 0, 0, 1, 1);
        check("lit_lock_rej_a", 32'(rej_a), 32'd1);
        check("lit_lock_sel_a", 32'(sel_a), 32'd0);
        step(1, 0, 0, 1, 0, 1);
        step(1, 0, 0, 1, 0, 1);
        step(1, 0, 0, 0, 1, 1);
        check("lit_lock_ok_rej_a", 32'(rej_a), 32'd0);
        check("lit_lock_ok_sel_a", 32'(sel_a), 32'd0);
        lock = 1'b0;
        step(1, 0, 0, 1, 0, 1);
        step(1, 1, 0, 1, 0, 1);
        step(1, 0, 0, 0, 1, 1);
        check("lit_unlock_sel_a", 32'(sel_a), 32'd2);
        lock = 1'b1;
        step(1, 0, 0, 0, 0, 1);
        check("lit_lock_force_a", 32'(sel_a), 32'd0);
        lock = 1'b0;
`endif

        // Randomised traffic; the compare process does the checking.
        for (int n = 0; n < 600; n++) begin
`ifdef FIREBIRD7_SCANMUX_SECURE_LOCK_EN
            if ($urandom_range(0, 15) == 0) lock = ~lock;
`endif
            step(1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom_range(0, 4) == 0),
                 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0));
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
